ahb_bridge_arbiter: RTL
=======================

Name: ahb_bridge_arbiter

Overview:
- Shares the single AHB slave port of the AHB-to-APB bridge among NUM_MASTERS AHB masters.
- Round-robin arbitration with a bounded hold per owner and default-master parking on master 0.
- Drives the address/control mux from the address-phase owner and the write-data mux from the data-phase owner.
- Sits between the master interfaces and the bridge's hwrite/hready_in/htrans/hwdata/haddr inputs.

Parameters:
- NUM_MASTERS, 3, number of requesting masters (2..4).
- MST_W, 2, width of the master index; must hold NUM_MASTERS-1.
- MAX_HOLD, 4, maximum number of completed transfers (NONSEQ/SEQ) one owner keeps while others request (1..15).

Ports:
- hclk  input  1  bus clock; all state changes on its rising edge.
- hresetn  input  1  asynchronous active-low reset.
- hbusreq  input  NUM_MASTERS  per-master bus request.
- htrans_m  input  2*NUM_MASTERS  per-master htrans; master i uses bits [2i+1:2i].
- haddr_m  input  32*NUM_MASTERS  per-master haddr.
- hwrite_m  input  NUM_MASTERS  per-master hwrite.
- hwdata_m  input  32*NUM_MASTERS  per-master hwdata.
- hr_readyout  input  1  bridge ready, also broadcast to masters.
- hgrant  output  NUM_MASTERS  one-hot grant.
- hmaster  output  MST_W  index of the address-phase owner.
- htrans  output  2  muxed htrans to bridge.
- haddr  output  32  muxed haddr to bridge.
- hwrite  output  1  muxed hwrite to bridge.
- hwdata  output  32  muxed hwdata, selected by the data-phase owner.
- hready_in  output  1  hready to bridge and masters; equals hr_readyout combinationally.

Behaviour:
- Reset (hresetn=0, asynchronous): hgrant=...001, hmaster=0, data-phase owner hmaster_d=0, hold_cnt=0, state=PARK, rr_ptr=0.
- Muxes are combinational: htrans/haddr/hwrite come from master[hmaster]; hwdata comes from master[hmaster_d].
- The registered grant/owner updates only on a rising edge with hr_readyout=1. With hr_readyout=0 everything holds.
- On every edge with hr_readyout=1: hmaster_d <= hmaster. This aligns the data phase with AHB pipelining.
- FSM states:
  - PARK: no owner; master 0 is granted as default master.
    - On hready with any hbusreq set, grant the first requester at or after rr_ptr (circular search) and go to OWN.
    - A request from master 0 in PARK also moves to OWN, owner 0.
  - OWN:
    - A transfer completes on hready with htrans[1]=1; each completion increments hold_cnt.
    - Rearbitrate on hready when the owner's hbusreq=0, OR when hold_cnt=MAX_HOLD-1 and a transfer completes this cycle while another master requests.
    - Rearbitration picks the next requester after the owner (circular); rr_ptr <= winner+1 mod NUM_MASTERS; hold_cnt <= 0.
    - If no one else requests and the owner still requests: the owner keeps the grant and hold_cnt saturates at MAX_HOLD-1.
    - If nobody requests: return to PARK with master 0.
- Grant latency: a request seen on an hready edge is granted at that edge. The new owner's first address phase is the next cycle.
- The owner must not change while the owner's htrans=BUSY (01) unless its hbusreq=0.
- A new grant to a master never happens while hr_readyout=0, even if requests change.
- Simultaneous requests in PARK: the winner is the lowest index at or after rr_ptr.
- Reset mid-transfer: the grant returns to master 0 immediately; any in-flight transfer is dropped.

Optional Feature:
- ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins. There is no MAX_HOLD preemption; a higher-priority request preempts the owner at the next hready edge that completes a transfer or sees htrans=IDLE. rr_ptr is unused and held at 0.
- Undefined: round-robin as above.

Test Plan:
- Reset, no requests: hgrant=001, hmaster=0, haddr=haddr_m[31:0] -> stays PARK for 10 cycles.
- Master 1 requests alone and does a single NONSEQ write to addr 0x8000_0004, data 0xA5A5_0001:
  - hgrant=010 one edge after hbusreq.
  - haddr=0x8000_0004 in the address phase.
  - hwdata=0xA5A5_0001 in the next cycle, selected via hmaster_d=1.
- Masters 0, 1 and 2 request continuously with back-to-back transfers, MAX_HOLD=4 -> grant sequence 0,1,2,0, each holding exactly 4 transfers.
- Owner 2 mid-transfer with hr_readyout held 0 for 3 cycles while master 0 requests -> hgrant, hmaster and hmaster_d unchanged until hr_readyout=1.
- Assert hresetn=0 during master 1's data phase -> hgrant=001 and hmaster=0 within the same cycle with no clock edge; after release, a master 2 request is granted first.
- ARB_FIXED_PRIO_EN: master 2 owns the bus and master 0 requests -> grant moves to 0 on the next hready edge with a completed transfer; master 2 is regranted only after master 0 drops hbusreq.

Source files
------------

// File: rtl/ahb_bridge_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_bridge_arbiter
//
// Purpose:
//   Shares the single AHB slave port of the AHB-to-APB bridge among
//   NUM_MASTERS AHB masters.
//   - The default build uses round-robin arbitration. Each owner keeps the bus
//     for at most MAX_HOLD completed transfers while other masters are
//     requesting. When nobody requests, the bus parks on master 0.
//   - Defining ARB_FIXED_PRIO_EN selects fixed priority instead: the lowest
//     index wins, and there is no hold limit.
//   - The address/control mux follows the address-phase owner (hmaster).
//   - The write-data mux follows the data-phase owner (hmaster_d), which
//     lags hmaster by one hready edge.
//
// Handshake:
//   hr_readyout is the only flow control. The arbiter state and both owner
//   registers change only on a rising hclk edge where hr_readyout=1. On any
//   edge with hr_readyout=0, every register holds.
//
// Ports:
//   hclk         bus clock; all state changes occur on its rising edge
//   hresetn      asynchronous active-low reset
//   hbusreq      per-master bus request
//   htrans_m     per-master htrans (master i on bits [2i+1:2i])
//   haddr_m      per-master haddr  (master i on bits [32i+31:32i])
//   hwrite_m     per-master hwrite
//   hwdata_m     per-master hwdata (master i on bits [32i+31:32i])
//   hr_readyout  bridge ready
//   hgrant       one-hot grant (decoded from hmaster)
//   hmaster      index of the address-phase owner
//   htrans       muxed htrans to the bridge
//   haddr        muxed haddr to the bridge
//   hwrite       muxed hwrite to the bridge
//   hwdata       muxed hwdata to the bridge, selected by the data-phase owner
//   hready_in    hready to the bridge and to the masters (= hr_readyout)
//
// Configuration macro: ARB_FIXED_PRIO_EN (undefined = round-robin).
// ---------------------------------------------------------------------------
module ahb_bridge_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int MST_W       = 2,
  parameter int MAX_HOLD    = 4
) (
  input  logic                      hclk,
  input  logic                      hresetn,
  input  logic [NUM_MASTERS-1:0]    hbusreq,
  input  logic [2*NUM_MASTERS-1:0]  htrans_m,
  input  logic [32*NUM_MASTERS-1:0] haddr_m,
  input  logic [NUM_MASTERS-1:0]    hwrite_m,
  input  logic [32*NUM_MASTERS-1:0] hwdata_m,
  input  logic                      hr_readyout,
  output logic [NUM_MASTERS-1:0]    hgrant,
  output logic [MST_W-1:0]          hmaster,
  output logic [1:0]                htrans,
  output logic [31:0]               haddr,
  output logic                      hwrite,
  output logic [31:0]               hwdata,
  output logic                      hready_in
);

  typedef enum logic {
    PARK = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
  localparam logic [1:0] TRANS_IDLE = 2'b00;

  arb_state_t       state, state_nx;
  logic [MST_W-1:0] hmaster_d;
  logic [MST_W-1:0] owner_nx;
  logic [3:0]       hold_cnt, hold_nx;
  logic [MST_W-1:0] rr_ptr, rr_nx;

  logic             owner_req;
  logic             others_req;
  logic             xfer_done;
  logic             hold_last;
  logic [MST_W-1:0] park_win;
  logic [MST_W-1:0] rearb_win;
  logic [MST_W-1:0] after_owner;

  // Returns the first requester found by a circular search that starts at
  // index 'start'. Callers make sure that req is not all zero.
  function automatic logic [MST_W-1:0] rr_pick(
    input logic [NUM_MASTERS-1:0] req,
    input logic [MST_W-1:0]       start
  );
    logic [MST_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = (int'(start) + k) % NUM_MASTERS;
      if (!found && req[idx]) begin
        pick  = MST_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Returns the index after w, wrapping back to 0 after the last master.
  function automatic logic [MST_W-1:0] next_of(input logic [MST_W-1:0] w);
    return MST_W'((int'(w) + 1) % NUM_MASTERS);
  endfunction

  // -------------------------------------------------------------------------
  // Combinational muxes: the address/control path follows hmaster, and the
  // write-data path follows hmaster_d.
  // -------------------------------------------------------------------------
  always_comb begin
    hgrant = '0;
    htrans = '0;
    haddr  = '0;
    hwrite = 1'b0;
    hwdata = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (hmaster == MST_W'(i)) begin
        hgrant[i] = 1'b1;
        htrans    = htrans_m[2*i +: 2];
        haddr     = haddr_m[32*i +: 32];
        hwrite    = hwrite_m[i];
      end
      if (hmaster_d == MST_W'(i)) begin
        hwdata = hwdata_m[32*i +: 32];
      end
    end
  end

  assign hready_in = hr_readyout;

  // -------------------------------------------------------------------------
  // Arbitration terms. hgrant is the one-hot form of the current owner.
  // -------------------------------------------------------------------------
  assign owner_req   = |(hbusreq & hgrant);
  assign others_req  = |(hbusreq & ~hgrant);
  assign xfer_done   = htrans[1];  // NONSEQ or SEQ completes on hready
  assign hold_last   = (hold_cnt == HOLD_LAST);
  assign after_owner = next_of(hmaster);

`ifdef ARB_FIXED_PRIO_EN
  assign park_win  = rr_pick(hbusreq, '0);
  assign rearb_win = rr_pick(hbusreq, '0);
`else
  assign park_win  = rr_pick(hbusreq, rr_ptr);
  // The owner is masked out, so a preemption always moves the bus to a
  // different master.
  assign rearb_win = rr_pick(hbusreq & ~hgrant, after_owner);
`endif

  // -------------------------------------------------------------------------
  // Next-state logic. Nothing moves unless hr_readyout=1. As a result, a new
  // grant never appears during a wait state.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    owner_nx = hmaster;
    hold_nx  = hold_cnt;
    rr_nx    = rr_ptr;
    if (hr_readyout) begin
      unique case (state)
        PARK: begin
          if (|hbusreq) begin
            state_nx = OWN;
            owner_nx = park_win;
            hold_nx  = '0;
`ifndef ARB_FIXED_PRIO_EN
            rr_nx    = next_of(park_win);
`endif
          end
        end
        OWN: begin
          if (!owner_req) begin
            // The owner has let go of the bus. The owner may release it
            // even while it is driving BUSY.
            hold_nx = '0;
            if (others_req) begin
              owner_nx = rearb_win;
`ifndef ARB_FIXED_PRIO_EN
              rr_nx    = next_of(rearb_win);
`endif
            end else begin
              state_nx = PARK;
              owner_nx = '0;
            end
          end else begin
`ifdef ARB_FIXED_PRIO_EN
            // A higher-priority master may take over only at a transfer
            // boundary or when the owner is idle. It never takes over
            // while the owner is in BUSY.
            if ((rearb_win < hmaster) && (xfer_done || (htrans == TRANS_IDLE))) begin
              owner_nx = rearb_win;
              hold_nx  = '0;
            end else if (xfer_done && !hold_last) begin
              hold_nx = hold_cnt + 4'd1;
            end
`else
            if (xfer_done && hold_last && others_req) begin
              owner_nx = rearb_win;
              hold_nx  = '0;
              rr_nx    = next_of(rearb_win);
            end else if (xfer_done && !hold_last) begin
              // hold_cnt saturates at MAX_HOLD-1 while the owner is alone.
              hold_nx = hold_cnt + 4'd1;
            end
`endif
          end
        end
        default: begin
          state_nx = PARK;
          owner_nx = '0;
          hold_nx  = '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Registers. On each hready edge, hmaster_d takes the value hmaster had
  // during the address phase that just ended.
  // -------------------------------------------------------------------------
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= PARK;
      hmaster   <= '0;
      hmaster_d <= '0;
      hold_cnt  <= '0;
      rr_ptr    <= '0;
    end else if (hr_readyout) begin
      state     <= state_nx;
      hmaster   <= owner_nx;
      hmaster_d <= hmaster;
      hold_cnt  <= hold_nx;
      rr_ptr    <= rr_nx;
    end
  end

endmodule
